// File: rtl/ftc_pkg.sv
// Shared definitions for the ftc_compressor block.
// Holds the default column count, the packed result type and ftc_ref(), a
// bit-accurate reference model of the whole compressor row that returns
// {cout, c, s} for one operand set.
package ftc_pkg;

    localparam int unsigned FtcWidth = 8;

    typedef logic [FtcWidth-1:0] ftc_word_t;

    typedef struct packed {
        logic      cout;
        ftc_word_t c;
        ftc_word_t s;
    } ftc_res_t;

    function automatic ftc_res_t ftc_ref(input ftc_word_t i1, input ftc_word_t i2,
                                         input ftc_word_t i3, input ftc_word_t i4,
                                         input logic cin);
        ftc_res_t res;
        logic     ci;
        logic     p;
        logic     g;
        res = '0;
        ci  = cin;
        for (int k = 0; k < int'(FtcWidth); k++) begin
            p        = i1[k] ^ i2[k] ^ i3[k] ^ i4[k];
            g        = (i1[k] & i2[k] & i3[k] & i4[k]) | ((i1[k] ^ i2[k]) & (i3[k] ^ i4[k]));
            res.s[k] = p ^ ci;
            res.c[k] = (p & ci) | g;
            // Lateral carry depends only on the operand bits, never on ci.
            ci       = (i1[k] & i2[k]) | (i3[k] & i4[k]);
        end
        res.cout = ci;
        return res;
    endfunction

endpackage

// File: rtl/ftc_if.sv
// Operand/result bus of the ftc_compressor.
// slave : the compressor (takes operands, drives results)
// master: the producer/consumer around it
// Signals: in_valid, i1..i4, cin (to compressor); out_valid, s, c, cout (from it).
interface ftc_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [WIDTH-1:0] i4;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic             cout;

    modport slave (
        input  in_valid, i1, i2, i3, i4, cin,
        output out_valid, s, c, cout
    );

    modport master (
        output in_valid, i1, i2, i3, i4, cin,
        input  out_valid, s, c, cout
    );
endinterface

// File: rtl/ftc_cell.sv
// One 5:3 compressor column: four operand bits plus a lateral carry-in reduce
// to sum S, carry C (next weight) and lateral carry Cout (next weight).
// Ports: a_i, b_i, d_i, e_i operand bits; ci_i lateral carry-in;
//        s_o sum; c_o carry; cout_o lateral carry-out (independent of ci_i).
module ftc_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic d_i,
    input  logic e_i,
    input  logic ci_i,
    output logic s_o,
    output logic c_o,
    output logic cout_o
);
    logic p;
    logic g;

    assign p      = a_i ^ b_i ^ d_i ^ e_i;
    assign g      = (a_i & b_i & d_i & e_i) | ((a_i ^ b_i) & (d_i ^ e_i));
    assign s_o    = p ^ ci_i;
    assign c_o    = (p & ci_i) | g;
    assign cout_o = (a_i & b_i) | (d_i & e_i);
endmodule

// File: rtl/ftc_compressor.sv
// Registered row of WIDTH 5:3 compressor cells for multi-operand adder trees.
// Row identity: i1+i2+i3+i4+cin = s + 2*c + 2^WIDTH*cout.
// Ports: clk, rst_n (async active-low); bus_io (ftc_if.slave) carrying
//        in_valid/i1..i4/cin in and out_valid/s/c/cout out, one cycle later.
// s/c/cout load only on in_valid and hold otherwise; out_valid follows
// in_valid every cycle.
module ftc_compressor
    import ftc_pkg::*;
#(
    parameter int unsigned WIDTH = FtcWidth
) (
    input  logic clk,
    input  logic rst_n,
    ftc_if.slave bus_io
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] c_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic             cout_q;
    logic             valid_q;

    assign carry[0] = bus_io.cin;

    // Cout of each cell needs no ci, so this chain is one cell deep, not a ripple.
    for (genvar k = 0; k < WIDTH; k++) begin : g_col
        ftc_cell u_cell (
            .a_i    (bus_io.i1[k]),
            .b_i    (bus_io.i2[k]),
            .d_i    (bus_io.i3[k]),
            .e_i    (bus_io.i4[k]),
            .ci_i   (carry[k]),
            .s_o    (s_d[k]),
            .c_o    (c_d[k]),
            .cout_o (carry[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus_io.in_valid;
            if (bus_io.in_valid) begin
                s_q    <= s_d;
                c_q    <= c_d;
                cout_q <= carry[WIDTH];
            end
        end
    end

    assign bus_io.s         = s_q;
    assign bus_io.c         = c_q;
    assign bus_io.cout      = cout_q;
    assign bus_io.out_valid = valid_q;
endmodule

// File: tb/tb_ftc_compressor.sv
// Directed and random checks of ftc_compressor (WIDTH=8): reset, hand-computed
// vectors, hold/stall, column-0 sweep and random traffic with a reset pulse.
module tb_ftc_compressor;
    import ftc_pkg::*;

    localparam int unsigned W = FtcWidth;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    ftc_if #(.WIDTH(W)) bus ();

    ftc_compressor #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input ftc_word_t a, input ftc_word_t b,
                         input ftc_word_t d, input ftc_word_t e, input logic ci);
        bus.in_valid = v;
        bus.i1       = a;
        bus.i2       = b;
        bus.i3       = d;
        bus.i4       = e;
        bus.cin      = ci;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input ftc_res_t exp, input logic exp_v);
        check_eq({tag, ".s"}, 32'(bus.s), 32'(exp.s));
        check_eq({tag, ".c"}, 32'(bus.c), 32'(exp.c));
        check_eq({tag, ".cout"}, 32'(bus.cout), 32'(exp.cout));
        check_eq({tag, ".valid"}, 32'(bus.out_valid), 32'(exp_v));
    endtask

    function automatic ftc_res_t mk(input ftc_word_t s, input ftc_word_t c, input logic co);
        ftc_res_t r;
        r.s    = s;
        r.c    = c;
        r.cout = co;
        return r;
    endfunction

    initial begin
        ftc_res_t  exp_q;
        ftc_word_t a, b, d, e;
        logic      ci, v;
        logic [4:0] bits;
        int        sum, got;

        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        check_out("reset", mk(8'h00, 8'h00, 1'b0), 1'b0);
        #9 rst_n = 1'b1;

        // Single bit
        drive(1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        check_out("single", mk(8'h01, 8'h00, 1'b0), 1'b1);

        // Pair carries: 255+255 = 510
        drive(1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
        step();
        check_out("pair", mk(8'hFE, 8'h00, 1'b1), 1'b1);

        // Saturation: 4*255+1 = 1021
        drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        step();
        check_out("sat", mk(8'hFF, 8'hFF, 1'b1), 1'b1);

        // Hold during a 3-cycle stall with changing inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h12 + 8'(i), 8'h34, 8'h56, 8'h78, 1'(i));
            step();
            check_out("stall", mk(8'hFF, 8'hFF, 1'b1), 1'b0);
        end

        // Asynchronous reset between edges drops the in-flight operand set
        drive(1'b1, 8'h0F, 8'hF0, 8'h33, 8'hCC, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_out("areset", mk(8'h00, 8'h00, 1'b0), 1'b0);
        drive(1'b0, 8'h0F, 8'hF0, 8'h33, 8'hCC, 1'b1);
        rst_n = 1'b1;
        step();
        check_out("post_reset", mk(8'h00, 8'h00, 1'b0), 1'b0);

        // Column-0 sweep of all (a,b,d,e,ci)
        for (int i = 0; i < 32; i++) begin
            bits = 5'(i);
            drive(1'b1, {7'd0, bits[0]}, {7'd0, bits[1]}, {7'd0, bits[2]}, {7'd0, bits[3]},
                  bits[4]);
            step();
            check_out("col0", ftc_ref({7'd0, bits[0]}, {7'd0, bits[1]}, {7'd0, bits[2]},
                                      {7'd0, bits[3]}, bits[4]), 1'b1);
            check_eq("col0.parity", 32'(bus.s[0]), 32'(^bits));
            got = int'(bus.s) + 2 * int'(bus.c) + 256 * int'(bus.cout);
            check_eq("col0.row", 32'(got), 32'($countones(bits)));
        end

        // Random traffic with a mid-stream reset pulse
        exp_q = ftc_ref({7'd0, bits[0]}, {7'd0, bits[1]}, {7'd0, bits[2]}, {7'd0, bits[3]},
                        bits[4]);
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                rst_n = 1'b0;
                #1;
                check_out("rnd_reset", mk(8'h00, 8'h00, 1'b0), 1'b0);
                rst_n = 1'b1;
                exp_q = '0;
            end
            v  = ($urandom_range(0, 9) != 0);
            a  = 8'($urandom);
            b  = 8'($urandom);
            d  = 8'($urandom);
            e  = 8'($urandom);
            ci = 1'($urandom);
            drive(v, a, b, d, e, ci);
            step();
            if (v) exp_q = ftc_ref(a, b, d, e, ci);
            check_out("rnd", exp_q, v);
            if (v) begin
                sum = int'(a) + int'(b) + int'(d) + int'(e) + int'(ci);
                got = int'(bus.s) + 2 * int'(bus.c) + 256 * int'(bus.cout);
                check_eq("rnd.row", 32'(got), 32'(sum));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
